// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Booth triplet codes {q[1], q[0], q_m1}.
  localparam logic [2:0] TRIP_000 = 3'b000;
  localparam logic [2:0] TRIP_001 = 3'b001;
  localparam logic [2:0] TRIP_010 = 3'b010;
  localparam logic [2:0] TRIP_011 = 3'b011;
  localparam logic [2:0] TRIP_100 = 3'b100;
  localparam logic [2:0] TRIP_101 = 3'b101;
  localparam logic [2:0] TRIP_110 = 3'b110;
  localparam logic [2:0] TRIP_111 = 3'b111;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_POS1 = 3'd1,
    PP_POS2 = 3'd2,
    PP_NEG1 = 3'd3,
    PP_NEG2 = 3'd4
  } pp_sel_t;

  // Map a Booth triplet onto the partial-product multiple it selects.
  function automatic pp_sel_t booth_select(input logic [2:0] triplet);
    pp_sel_t sel;
    case (triplet)
      TRIP_000, TRIP_111: sel = PP_ZERO;
      TRIP_001, TRIP_010: sel = PP_POS1;
      TRIP_011:           sel = PP_POS2;
      TRIP_100:           sel = PP_NEG2;
      TRIP_101, TRIP_110: sel = PP_NEG1;
      default:            sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: turns one multiplier triplet and the multiplicand
// into the WIDTH+2-bit signed partial product (0, +-M, +-2M).
module booth_r4_recode
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp
);

  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] m_dbl;
  pp_sel_t          sel;

  // Two guard bits keep +-2M exact, including 2 * (-2^(WIDTH-1)).
  assign m_ext = {{2{m[WIDTH-1]}}, m};
  assign m_dbl = {m_ext[WIDTH:0], 1'b0};
  assign sel   = booth_select(triplet);

  // Select the partial product for this digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pp = '0;
    case (sel)
      PP_POS1: pp = m_ext;
      PP_POS2: pp = m_dbl;
      PP_NEG1: pp = -m_ext;
      PP_NEG2: pp = -m_dbl;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_r4.sv
// Iterative radix-4 Booth multiplier: retires two multiplier bits per clock
// and presents the exact 2*WIDTH-bit signed product while op_done is high.
// WIDTH must be even and at least 4.
module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int            STEPS = WIDTH / 2;
  localparam int            CW    = $clog2(STEPS);
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH+1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] a_next;
  logic [WIDTH-1:0] q_next;

  booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
    .triplet ({q_reg[1:0], q_m1}),
    .m       (m_reg),
    .pp      (pp)
  );

  // Add the partial product, then arithmetic-shift {A,Q} right by two.
  always_comb begin
    sum    = a_reg + pp;
    a_next = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    q_next = {sum[1:0], q_reg[WIDTH-1:2]};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: clear beats everything; DONE only exits via clear.
  always_comb begin
    state_next = state;
    if (op_clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (op_start) state_next = ST_BUSY;
        ST_BUSY: if (count == LAST) state_next = ST_DONE;
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand latch on start, one Booth step per BUSY cycle, result capture on the last step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      m_reg  <= '0;
      count  <= '0;
      result <= '0;
    end else if (op_clear) begin
      a_reg  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        ST_BUSY: begin
          a_reg <= a_next;
          q_reg <= q_next;
          q_m1  <= q_reg[1];
          count <= count + 1'b1;
          if (count == LAST) result <= {a_next[WIDTH-1:0], q_next};
        end
        default: ;
      endcase
    end
  end

  assign op_done = (state == ST_DONE);

endmodule
